// File: rtl/rv32i_mc_core.sv
// Multicycle RV32I core: FETCH -> DECODE -> EXECUTE (-> WAIT_DATA for loads), halting on SYSTEM.
// One external memory port with 1-cycle read latency, plus a registered writeback trace port.
module rv32i_mc_core #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        halt,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StWaitData, StHalt} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]           instr_q, rs1_q, rs2_q;
  logic [31:0]           rf [32];
  logic                  rf_we;
  logic [31:0]           rf_wdata;
  logic                  wb_valid_q;
  logic [4:0]            wb_rd_q;
  logic [31:0]           wb_data_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_ext, ls_addr, br_target, jal_target, jalr_target;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rd     = instr_q[11:7];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  assign pc_ext      = 32'(pc_q);
  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign ls_addr     = rs1_q + ((opcode == OpStore) ? imm_s : imm_i);
  assign br_target   = pc_ext + imm_b;
  assign jal_target  = pc_ext + imm_j;
  assign jalr_target = (rs1_q + imm_i) & ~32'd1;

  // Upper address bits beyond ADDR_WIDTH are intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^{ls_addr, br_target, jal_target, jalr_target};

  // ALU
  logic [31:0] alu_op2, alu_out;
  logic [4:0]  shamt;
  always_comb begin
    alu_op2 = (opcode == OpReg) ? rs2_q : imm_i;
    shamt   = (opcode == OpReg) ? rs2_q[4:0] : instr_q[24:20];
    alu_out = 32'd0;
    case (funct3)
      3'b000:  alu_out = (opcode == OpReg && instr_q[30]) ? rs1_q - alu_op2 : rs1_q + alu_op2;
      3'b001:  alu_out = rs1_q << shamt;
      3'b010:  alu_out = {31'd0, $signed(rs1_q) < $signed(alu_op2)};
      3'b011:  alu_out = {31'd0, rs1_q < alu_op2};
      3'b100:  alu_out = rs1_q ^ alu_op2;
      3'b101:  alu_out = instr_q[30] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'b110:  alu_out = rs1_q | alu_op2;
      default: alu_out = rs1_q & alu_op2;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_q == rs2_q);
      3'b001:  br_taken = (rs1_q != rs2_q);
      3'b100:  br_taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_taken = (rs1_q < rs2_q);
      3'b111:  br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  // Load extraction and store lane steering
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_mask;
  always_comb begin
    case (ls_addr[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
    case (funct3[1:0])
      2'b00: begin
        st_mask   = 4'b0001 << ls_addr[1:0];
        mem_wdata = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        st_mask   = 4'b0011 << {ls_addr[1], 1'b0};
        mem_wdata = {2{rs2_q[15:0]}};
      end
      default: begin
        st_mask   = 4'b1111;
        mem_wdata = rs2_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mem_addr  = pc_ext;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    rf_we     = 1'b0;
    rf_wdata  = 32'd0;
    unique case (state_q)
      StFetch: begin
        mem_rstrb = 1'b1;
        state_d   = StDecode;
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        state_d = StFetch;
        pc_d    = pc_plus4;
        case (opcode)
          OpImm, OpReg: begin
            rf_we    = 1'b1;
            rf_wdata = alu_out;
          end
          OpLui: begin
            rf_we    = 1'b1;
            rf_wdata = imm_u;
          end
          OpAuipc: begin
            rf_we    = 1'b1;
            rf_wdata = pc_ext + imm_u;
          end
          OpJal: begin
            rf_we    = 1'b1;
            rf_wdata = 32'(pc_plus4);
            pc_d     = jal_target[ADDR_WIDTH-1:0];
          end
          OpJalr: begin
            rf_we    = 1'b1;
            rf_wdata = 32'(pc_plus4);
            pc_d     = jalr_target[ADDR_WIDTH-1:0];
          end
          OpBranch: if (br_taken) pc_d = br_target[ADDR_WIDTH-1:0];
          OpStore: begin
            mem_addr  = 32'(ls_addr[ADDR_WIDTH-1:0]);
            mem_wmask = st_mask;
          end
          OpLoad: begin
            mem_addr  = 32'(ls_addr[ADDR_WIDTH-1:0]);
            mem_rstrb = 1'b1;
            pc_d      = pc_q;
            state_d   = StWaitData;
          end
          OpSystem: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
      end
      StWaitData: begin
        rf_we    = 1'b1;
        rf_wdata = ld_data;
        pc_d     = pc_plus4;
        state_d  = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StFetch;
      pc_q       <= RESET_ADDR[ADDR_WIDTH-1:0];
      instr_q    <= Nop;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wb_valid_q <= rf_we && (rd != 5'd0);
      if (state_q == StDecode) begin
        instr_q <= mem_rdata;
        rs1_q   <= (mem_rdata[19:15] == 5'd0) ? 32'd0 : rf[mem_rdata[19:15]];
        rs2_q   <= (mem_rdata[24:20] == 5'd0) ? 32'd0 : rf[mem_rdata[24:20]];
      end
      if (rf_we && rd != 5'd0) begin
        wb_rd_q   <= rd;
        wb_data_q <= rf_wdata;
      end
    end
  end

  // Register file deliberately has no reset.
  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0) rf[rd] <= rf_wdata;
  end

  assign halt     = (state_q == StHalt);
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: doc/rv32i_mc_core.md
# rv32i_mc_core

Parametrised multicycle RV32I core: the successor to our three-state fetch/register/execute datapath, adding the full RV32I base ISA (branches, LUI/AUIPC, byte/half/word loads and stores), an external memory port, a halt state and a writeback trace port. It sits inside the SoC between the slow-clock generator and the memory/peripheral decode. The LED mirror and testbench observation are driven from its trace port.

## Interface
- `ADDR_WIDTH`, default 24: implemented PC/address bits. `mem_addr` and PC-derived values are zero-extended above this width.
- `RESET_ADDR`, default 32'h0000_0000: PC value after reset.
- `clk` input, 1: core clock, all logic on posedge.
- `resetn` input, 1: reset, asynchronous, active-low.
- `mem_addr` output, 32: byte address of the current access.
- `mem_rstrb` output, 1: read request; data is returned on `mem_rdata` exactly 1 cycle later.
- `mem_rdata` input, 32: read data.
- `mem_wdata` output, 32: store data, replicated per size (byte ×4, half ×2).
- `mem_wmask` output, 4: byte write enables; nonzero for exactly one cycle per store.
- `halt` output, 1: core stopped on SYSTEM opcode.
- `wb_valid` output, 1: register-file write this cycle (rd≠0).
- `wb_rd` output, 5: destination register of the write.
- `wb_data` output, 32: value written.

## Operation
- States: FETCH (drive `mem_addr`=PC, `mem_rstrb`=1) → DECODE (latch `instr`<=`mem_rdata`; read rs1/rs2 from the register file using the rdata fields) → EXECUTE → FETCH. Exceptions: a load goes EXECUTE → WAIT_DATA → FETCH; a SYSTEM opcode goes EXECUTE → HALT.
- EXECUTE:
  - ALU reg/imm: writeback.
  - LUI: rd=Uimm.
  - AUIPC: rd=PC+Uimm.
  - JAL: rd=PC+4, PC=PC+Jimm.
  - JALR: rd=PC+4, PC=(rs1+Iimm)&~1.
  - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): PC=PC+Bimm if taken, else PC+4.
  - Store: `mem_addr`=rs1+Simm, `mem_wmask`/`mem_wdata` asserted this cycle, PC+4.
  - Load: `mem_addr`=rs1+Iimm, `mem_rstrb`=1.
- WAIT_DATA: extract byte (`addr[1:0]`) or half (`addr[1]`) from `mem_rdata`, sign- or zero-extend per funct3, write rd, PC+4.
- ALU:
  - SUB only when opcode is reg-reg and funct7[5]=1.
  - SRA when funct7[5]=1.
  - Shift amount is rs2[4:0] or instr[24:20].
  - SLT is signed, SLTU is unsigned.
- Misalignment: not trapped; low address bits are ignored for word (`[1:0]`) and half (`[0]`) accesses. Store mask: SB `4'b0001<<addr[1:0]`, SH `4'b0011<<{addr[1],1'b0}`, SW `4'b1111`.
- x0: reads 0; writes to rd=0 are discarded and `wb_valid` stays 0.
- FENCE and unknown opcodes: executed as NOP (PC+4, no write).
- SYSTEM (ECALL/EBREAK/CSR*): HALT, `halt`=1. No further memory activity until reset.
- Register file: not reset. Software must initialise registers before reading them.

## Timing
- Reset (async, immediate):
  - PC=RESET_ADDR, state=FETCH, `instr`=NOP.
  - `mem_rstrb`=1 (FETCH), `mem_wmask`=0, `halt`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
  - A store or load in flight is aborted with no partial write.
- First fetch: `mem_rstrb` is high in the first cycle after `resetn` deasserts.
- Latency in cycles:
  - ALU/LUI/AUIPC/jump/branch/store/NOP: 3 (FETCH, DECODE, EXECUTE).
  - Load: 4.
- Writeback: `wb_*` are registered outputs, valid the cycle after the write state (EXECUTE or WAIT_DATA), high for 1 cycle.
- Memory port:
  - `mem_rstrb` and `mem_wmask` are never both nonzero.
  - `mem_addr` equals PC in every state except EXECUTE of a load or store.
- HALT is terminal. `mem_rstrb`=0 and `mem_wmask`=0 there.
- PC arithmetic:
  - Mod 2^ADDR_WIDTH: PC+4 at the top address wraps to 0.
  - Target bits above ADDR_WIDTH are dropped.
  - JAL/JALR link values are zero-extended.

## Test plan
- ADDI x1,x0,5; ADDI x1,x1,-7 at 0x0 → `wb` x1=0x00000005 then 0xFFFFFFFE, `wb_valid` pulses 3 cycles apart; ADDI x0,x0,1 → no `wb_valid`.
- x2=0x80000000: SRAI x3,x2,4 → 0xF8000000; SRLI → 0x08000000; SUB x4,x0,x2 → 0x80000000; SLT x5,x2,x0 → 1; SLTU x5,x2,x0 → 0.
- Store 0x12345678 (SW) to 0x100, then loads:
  - `mem_wmask`=1111 for one cycle.
  - LB 0x101 → 0x00000056; LB 0x103 → 0x00000012.
  - LH 0x102 → 0x00001234; LBU from a byte 0xF0 → 0x000000F0; LB from that byte → 0xFFFFFFF0.
  - SB 0xAB to 0x102 → wmask 0100, wdata 0xABABABAB.
- Control flow:
  - JAL x1,+8 at 0x10 → x1=0x14, next fetch 0x18.
  - JALR x0,x1,5 → fetch 0x18 (LSB cleared).
  - BNE countdown loop x1=3→0 → 3 taken branches, falls through at PC+4.
  - BLTU 0xFFFFFFFF vs 1 → not taken.
- EBREAK at 0x20:
  - `halt`=1 after EXECUTE; no `mem_rstrb` for 50 cycles.
  - `resetn` low → `halt`=0 immediately; fetch restarts at RESET_ADDR.
- Async reset mid-op:
  - Assert `resetn` low during a store's EXECUTE → `mem_wmask` drops to 0 the same cycle; memory unchanged.
  - Assert it during WAIT_DATA → no `wb_valid`.
